// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier datapath and its BCD display converter.
package multiplier_pkg;

    // Converter FSM encodings; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CONVERT = 2'b01,
        DONE    = 2'b10
    } conv_state_e;

    // One BCD digit is a 4-bit nibble.
    localparam int unsigned BCD_DIGIT_W    = 4;

    // Shift-and-add-3 correction: a digit of 5 or more gets 3 added before the shift.
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit double-dabble correction: in >= 5 ? in + 3 : in.
module bcd_digit_adjust
    import multiplier_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Pre-shift correction so the doubled digit carries correctly into the next digit.
    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            dout = din + BCD_DIGIT_W'(BCD_ADJ_ADD);
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the multiplier product.
// A rising edge on start captures bin_in; BIN_W cycles later the packed BCD
// digits and an overflow flag are published with a one-cycle valid pulse.
module product_bcd_converter
    import multiplier_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          valid,
    output logic                          overflow,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || DIGITS < 1) begin : g_bad_params
        $error("product_bcd_converter: BIN_W and DIGITS must both be at least 1");
    end

    conv_state_e        state_q,    state_d;
    logic               start_d_q;
    logic [BIN_W-1:0]   shift_q,    shift_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic               ovf_acc_q,  ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [ACC_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    logic                     trigger;
    logic [ACC_W-1:0]         acc_adj;
    logic [ACC_W+BIN_W-1:0]   shift_cat;
    logic                     carry_out;

    // Per-digit add-3 correction of the accumulator.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Rising-edge detect on start and one shift step of {ovf, acc, shift_reg}.
    always_comb begin
        trigger   = start & ~start_d_q;
        shift_cat = {acc_adj, shift_q} << 1;
        carry_out = acc_adj[ACC_W-1];
    end

    // Next-state, datapath and output-hold logic.
    // The hold registers are loaded on the final CONVERT edge with the last
    // shifted value, so bcd_out/overflow are already new during the DONE cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    shift_d   = bin_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                acc_d     = shift_cat[ACC_W+BIN_W-1:BIN_W];
                shift_d   = shift_cat[BIN_W-1:0];
                ovf_acc_d = ovf_acc_q | carry_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = shift_cat[ACC_W+BIN_W-1:BIN_W];
                    overflow_d = ovf_acc_q | carry_out;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            start_d_q  <= 1'b0;
            shift_q    <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_d_q  <= start;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy     = (state_q == CONVERT);
        valid    = (state_q == DONE);
        bcd_out  = bcd_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter: a 3-digit and a 2-digit instance share
// stimulus; expectations come from a table and from a decimal reference model.
module tb_product_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy, valid, overflow;
    logic [11:0] bcd3;
    logic        busy2, valid2, overflow2;
    logic [7:0]  bcd2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [11:0] prev3;
    logic        prev3o;
    logic [7:0]  prev2;
    logic        prev2o;

    always #5 clk = ~clk;

    product_bcd_converter #(.BIN_W(8), .DIGITS(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow),
        .bcd_out  (bcd3)
    );

    product_bcd_converter #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy2),
        .valid    (valid2),
        .overflow (overflow2),
        .bcd_out  (bcd2)
    );

    typedef struct {
        logic [7:0]  bin;
        int unsigned hold;
        logic [11:0] exp3;
        logic        ovf3;
        logic [7:0]  exp2;
        logic        ovf2;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: low 'digits' decimal digits packed as BCD, overflow if too large.
    function automatic void model(input int unsigned v, input int unsigned digits,
                                  output logic [31:0] bcd, output logic ovf);
        int unsigned lim = 1;
        int unsigned r;
        for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
        ovf = (v >= lim);
        r   = v % lim;
        bcd = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            bcd = bcd | ((r % 10) << (4 * i));
            r   = r / 10;
        end
    endfunction

    // One conversion from idle: start held for 'hold' cycles, bin_in scrambled after capture.
    task automatic convert(input logic [7:0] bin, input int unsigned hold,
                           input logic [11:0] e3, input logic e3o,
                           input logic [7:0] e2, input logic e2o, input string tag);
        int unsigned nvalid = 0, nvalid2 = 0, first = 0, nbusy = 0;
        bin_in = bin;
        start  = 1'b1;
        for (int unsigned c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (busy) nbusy++;
            if (valid2) nvalid2++;
            if (valid) begin
                nvalid++;
                if (first == 0) first = c;
                check({tag, " bcd3"}, 32'(bcd3), 32'(e3));
                check({tag, " ovf3"}, 32'(overflow), 32'(e3o));
                check({tag, " bcd2"}, 32'(bcd2), 32'(e2));
                check({tag, " ovf2"}, 32'(overflow2), 32'(e2o));
            end
            if (c == 4) begin
                check({tag, " hold bcd3"}, 32'(bcd3), 32'(prev3));
                check({tag, " hold ovf3"}, 32'(overflow), 32'(prev3o));
                check({tag, " hold bcd2"}, 32'(bcd2), 32'(prev2));
            end
            if (c == 2) bin_in = ~bin;
            if (c == hold) start = 1'b0;
        end
        start = 1'b0;
        check({tag, " latency"}, first, 9);
        check({tag, " busy cycles"}, nbusy, 8);
        check({tag, " valid count"}, nvalid, 1);
        check({tag, " valid2 count"}, nvalid2, 1);
        check({tag, " after bcd3"}, 32'(bcd3), 32'(e3));
        prev3 = e3; prev3o = e3o; prev2 = e2; prev2o = e2o;
    endtask

    initial begin
        logic [31:0] m3, m2;
        logic        o3, o2;
        int unsigned nv;

        vecs[0]  = '{8'd0,   1,  12'h000, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{8'd225, 1,  12'h225, 1'b0, 8'h25, 1'b1};
        vecs[2]  = '{8'd255, 20, 12'h255, 1'b0, 8'h55, 1'b1};
        vecs[3]  = '{8'd99,  1,  12'h099, 1'b0, 8'h99, 1'b0};
        vecs[4]  = '{8'd100, 1,  12'h100, 1'b0, 8'h00, 1'b1};
        vecs[5]  = '{8'd137, 3,  12'h137, 1'b0, 8'h37, 1'b1};
        vecs[6]  = '{8'd1,   1,  12'h001, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{8'd9,   1,  12'h009, 1'b0, 8'h09, 1'b0};
        vecs[8]  = '{8'd10,  2,  12'h010, 1'b0, 8'h10, 1'b0};
        vecs[9]  = '{8'd128, 1,  12'h128, 1'b0, 8'h28, 1'b1};
        vecs[10] = '{8'd200, 2,  12'h200, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{8'd64,  12, 12'h064, 1'b0, 8'h64, 1'b0};

        reset = 1'b1; start = 1'b0; bin_in = '0;
        prev3 = '0; prev3o = 1'b0; prev2 = '0; prev2o = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 0);
        check("reset valid", 32'(valid), 0);
        check("reset bcd3", 32'(bcd3), 0);
        check("reset ovf3", 32'(overflow), 0);
        check("reset bcd2", 32'(bcd2), 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, vecs[i].hold, vecs[i].exp3, vecs[i].ovf3,
                    vecs[i].exp2, vecs[i].ovf2, $sformatf("vec%0d", i));
        end

        // Second rising edge mid-conversion is ignored, not queued.
        nv = 0;
        bin_in = 8'd42; start = 1'b1;
        for (int unsigned c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                nv++;
                check("retrig bcd3", 32'(bcd3), 32'h042);
                check("retrig bcd2", 32'(bcd2), 32'h42);
            end
            if (c == 1) start = 1'b0;
            if (c == 2) begin bin_in = 8'd99; start = 1'b1; end
            if (c == 3) start = 1'b0;
        end
        check("retrig valid count", nv, 1);
        prev3 = 12'h042; prev3o = 1'b0; prev2 = 8'h42; prev2o = 1'b0;

        // Reset mid-conversion aborts immediately and clears the held result.
        nv = 0;
        bin_in = 8'd137; start = 1'b1;
        for (int unsigned c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        check("abort pre busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort valid", 32'(valid), 0);
        check("abort bcd3", 32'(bcd3), 0);
        check("abort bcd2", 32'(bcd2), 0);
        check("abort ovf2", 32'(overflow2), 0);
        @(negedge clk); reset = 1'b0;
        for (int unsigned c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (valid || valid2 || busy) nv++;
        end
        check("abort no activity", nv, 0);
        prev3 = '0; prev3o = 1'b0; prev2 = '0; prev2o = 1'b0;
        convert(8'd137, 1, 12'h137, 1'b0, 8'h37, 1'b1, "retry");

        // Random products against the decimal model.
        for (int i = 0; i < 20; i++) begin
            int unsigned v;
            v = $urandom_range(0, 255);
            model(v, 3, m3, o3);
            model(v, 2, m2, o2);
            convert(8'(v), $urandom_range(1, 3), m3[11:0], o3, m2[7:0], o2,
                    $sformatf("rnd%0d(%0d)", i, v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
